// File: rtl/sprite_palette_engine.sv
// Multi-bank runtime-writable sprite palette with a two-stage lookup pipeline,
// a transparency-key flag and a frame-counted white hit-flash overlay.
module sprite_palette_engine #(
  parameter int NUM_BANKS    = 4,
  parameter int INDEX_W      = 4,
  parameter int COLOR_W      = 4,
  parameter int KEY_INDEX    = 0,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         pix_valid,
  input  logic [$clog2(NUM_BANKS)-1:0] pix_bank,
  input  logic [INDEX_W-1:0]           pix_index,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_BANKS)-1:0] wr_bank,
  input  logic [INDEX_W-1:0]           wr_index,
  input  logic [3*COLOR_W-1:0]         wr_rgb,
  input  logic                         frame_start,
  input  logic                         flash_trig,
  output logic                         out_valid,
  output logic [COLOR_W-1:0]           out_red,
  output logic [COLOR_W-1:0]           out_green,
  output logic [COLOR_W-1:0]           out_blue,
  output logic                         out_transparent,
  output logic                         flash_active
);

  localparam int BANK_W  = $clog2(NUM_BANKS);
  localparam int ENTRIES = 2**INDEX_W;
  localparam int RGB_W   = 3*COLOR_W;
  localparam logic [INDEX_W-1:0] KEY        = INDEX_W'(KEY_INDEX);
  localparam logic [7:0]         FLASH_LOAD = 8'(FLASH_FRAMES);

  typedef enum logic {IDLE, FLASHING} state_t;

  // Flash overlay forces every channel to full scale.
  function automatic logic [RGB_W-1:0] apply_flash(input logic [RGB_W-1:0] rgb,
                                                   input logic             flash);
    return flash ? {RGB_W{1'b1}} : rgb;
  endfunction

  logic [RGB_W-1:0]   pal [NUM_BANKS][ENTRIES];
  logic [RGB_W-1:0]   rd_rgb;
  logic               key_hit;

  logic               vld_p1;
  logic [BANK_W-1:0]  bank_p1;
  logic [INDEX_W-1:0] index_p1;

  logic               vld_p2;
  logic [RGB_W-1:0]   rgb_p2;
  logic               key_p2;

  state_t             state, state_nxt;
  logic [7:0]         cnt, cnt_nxt;
  logic               phase, phase_nxt;

  // Palette storage; writes to a bank with no matching slot fall through untouched.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int i = 0; i < ENTRIES; i++)
          pal[b][i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NUM_BANKS; b++)
        if (wr_bank == BANK_W'(b)) pal[b][wr_index] <= wr_rgb;
    end
  end

  // ---- stage 1: capture request ----
  // Register the lookup request.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_p1   <= 1'b0;
      bank_p1  <= '0;
      index_p1 <= '0;
    end else begin
      vld_p1   <= pix_valid;
      bank_p1  <= pix_bank;
      index_p1 <= pix_index;
    end
  end

  // ---- stage 2: array read, key compare, flash overlay ----
  // Combinational read; an unmatched (out-of-range) bank reads as black.
  always_comb begin
    rd_rgb = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      if (bank_p1 == BANK_W'(b)) rd_rgb = pal[b][index_p1];
    key_hit = (index_p1 == KEY);
  end

  // Register the pixel; colour holds across idle cycles, key flag does not.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_p2 <= 1'b0;
      rgb_p2 <= '0;
      key_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      key_p2 <= vld_p1 & key_hit;
      if (vld_p1) rgb_p2 <= apply_flash(rd_rgb, phase & ~key_hit);
    end
  end

  assign out_valid       = vld_p2;
  assign out_red         = rgb_p2[RGB_W-1 -: COLOR_W];
  assign out_green       = rgb_p2[2*COLOR_W-1 -: COLOR_W];
  assign out_blue        = rgb_p2[COLOR_W-1:0];
  assign out_transparent = key_p2;
  assign flash_active    = (state == FLASHING);

  // Flash state, frame counter and blink phase registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      phase <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      phase <= phase_nxt;
    end
  end

  // Flash next-state: a trigger always (re)loads and beats a same-cycle frame tick.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    phase_nxt = phase;
    case (state)
      IDLE: begin
        if (flash_trig) begin
          state_nxt = FLASHING;
          cnt_nxt   = FLASH_LOAD;
          phase_nxt = 1'b1;
        end
      end
      FLASHING: begin
        if (flash_trig) begin
          cnt_nxt   = FLASH_LOAD;
          phase_nxt = 1'b1;
        end else if (frame_start) begin
          cnt_nxt   = cnt - 8'd1;
          phase_nxt = ~phase;
          if (cnt == 8'd1) begin
            state_nxt = IDLE;
            phase_nxt = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        phase_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sprite_palette_engine.sv
// Scoreboard bench for sprite_palette_engine: directed writes/lookups push
// expected pixels; a negedge monitor pops and compares every valid output.
module tb_sprite_palette_engine;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        pix_valid = 1'b0;
  logic [1:0]  pix_bank = '0;
  logic [3:0]  pix_index = '0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_bank = '0;
  logic [3:0]  wr_index = '0;
  logic [11:0] wr_rgb = '0;
  logic        frame_start = 1'b0;
  logic        flash_trig = 1'b0;
  logic        out_valid;
  logic [3:0]  out_red, out_green, out_blue;
  logic        out_transparent;
  logic        flash_active;

  typedef struct {
    logic [11:0] rgb;
    logic        t;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  sprite_palette_engine #(
    .NUM_BANKS(3), .INDEX_W(4), .COLOR_W(4), .KEY_INDEX(0), .FLASH_FRAMES(3)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .pix_valid(pix_valid), .pix_bank(pix_bank), .pix_index(pix_index),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_index(wr_index), .wr_rgb(wr_rgb),
    .frame_start(frame_start), .flash_trig(flash_trig),
    .out_valid(out_valid), .out_red(out_red), .out_green(out_green),
    .out_blue(out_blue), .out_transparent(out_transparent),
    .flash_active(flash_active)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    repeat (4) step();
  endtask

  task automatic wr(input logic [1:0] b, input logic [3:0] i, input logic [11:0] rgb);
    wr_en = 1'b1; wr_bank = b; wr_index = i; wr_rgb = rgb;
    step();
    wr_en = 1'b0;
  endtask

  task automatic issue(input logic [1:0] b, input logic [3:0] i,
                       input logic [11:0] rgb, input logic t);
    pix_valid = 1'b1; pix_bank = b; pix_index = i;
    sb.push_back('{rgb: rgb, t: t, cyc: cyc});
  endtask

  task automatic lookup(input logic [1:0] b, input logic [3:0] i,
                        input logic [11:0] rgb, input logic t);
    issue(b, i, rgb, t);
    step();
    pix_valid = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic pulse_trig();
    flash_trig = 1'b1;
    step();
    flash_trig = 1'b0;
  endtask

  // Monitor: every valid output must match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Reset_n === 1'b1 && out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got rgb %h with no pending request",
                   {out_red, out_green, out_blue});
        end else begin
          e = sb.pop_front();
          chk("pixel_rgb", {out_red, out_green, out_blue}, e.rgb);
          chk("pixel_key", out_transparent, e.t);
          chk("pixel_latency", cyc, e.cyc + 2);
        end
      end
    end
  end

  initial begin
    // Asynchronous reset mid-cycle
    #12 Reset_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_red", out_red, 0);
    chk("rst_green", out_green, 0);
    chk("rst_blue", out_blue, 0);
    chk("rst_key", out_transparent, 0);
    chk("rst_flash", flash_active, 0);
    step(); step();
    Reset_n = 1'b1;
    step();
    lookup(2'd1, 4'd5, 12'h000, 1'b0);
    drain();

    // Write then read back
    wr(2'd2, 4'd3, 12'hA65);
    step();
    lookup(2'd2, 4'd3, 12'hA65, 1'b0);
    lookup(2'd0, 4'd3, 12'h000, 1'b0);
    drain();

    // Streaming 16 back-to-back lookups
    for (int i = 0; i < 16; i++) wr(2'd0, 4'(i), 12'(12'h111 * i));
    for (int i = 0; i < 16; i++) lookup(2'd0, 4'(i), 12'(12'h111 * i), i == 0);
    drain();

    // Write at the stage-2 capture edge is not visible to that pixel
    wr(2'd1, 4'd4, 12'h123);
    step();
    issue(2'd1, 4'd4, 12'h123, 1'b0);
    step();
    pix_valid = 1'b0;
    wr(2'd1, 4'd4, 12'hFED);
    lookup(2'd1, 4'd4, 12'hFED, 1'b0);
    drain();
    chk("idle_valid", out_valid, 0);
    chk("idle_key", out_transparent, 0);
    chk("hold_red", out_red, 4'hF);
    chk("hold_green", out_green, 4'hE);

    // Flash sequence
    wr(2'd0, 4'd0, 12'h5A5);
    chk("flash_idle", flash_active, 0);
    pulse_trig();
    chk("flash_on", flash_active, 1);
    lookup(2'd0, 4'd2, 12'hFFF, 1'b0);
    lookup(2'd0, 4'd0, 12'h5A5, 1'b1);
    drain();
    pulse_frame();
    lookup(2'd0, 4'd2, 12'h222, 1'b0);
    drain();
    pulse_frame();
    lookup(2'd0, 4'd2, 12'hFFF, 1'b0);
    drain();
    chk("flash_fs2", flash_active, 1);
    pulse_frame();
    chk("flash_done", flash_active, 0);
    lookup(2'd0, 4'd2, 12'h222, 1'b0);
    drain();

    // Trigger beats a simultaneous frame tick and reloads the full count
    pulse_trig();
    pulse_frame();
    flash_trig = 1'b1; frame_start = 1'b1;
    step();
    flash_trig = 1'b0; frame_start = 1'b0;
    lookup(2'd0, 4'd2, 12'hFFF, 1'b0);
    drain();
    pulse_frame();
    lookup(2'd0, 4'd2, 12'h222, 1'b0);
    drain();
    pulse_frame();
    chk("reload_fs2", flash_active, 1);
    pulse_frame();
    chk("reload_done", flash_active, 0);

    // Out-of-range bank
    wr(2'd3, 4'd3, 12'hFFF);
    lookup(2'd0, 4'd3, 12'h333, 1'b0);
    lookup(2'd1, 4'd3, 12'h000, 1'b0);
    lookup(2'd2, 4'd3, 12'hA65, 1'b0);
    lookup(2'd3, 4'd3, 12'h000, 1'b0);
    drain();

    // Reset mid-flash clears state and palette
    pulse_trig();
    chk("pre_rst_flash", flash_active, 1);
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_mid_flash", flash_active, 0);
    chk("rst_mid_red", out_red, 0);
    step();
    Reset_n = 1'b1;
    step();
    lookup(2'd2, 4'd3, 12'h000, 1'b0);
    drain();

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_palette_engine.md
Name: sprite_palette_engine

Overview:
- Parametrised, runtime-writable colour palette for sprite pixel lookup; next generation of the fixed 16-entry 4-bit RGB sprite palettes.
- Holds NUM_BANKS palettes so one sprite sheet can be recoloured, e.g. player 1 and player 2 costumes.
- Pipelined 2-cycle lookup with transparency-key flag and a frame-counted hit-flash effect.
- Sits between the sprite ROM index output and the VGA colour mux.

Parameters:
- NUM_BANKS, 4, number of palettes (>=2).
- INDEX_W, 4, palette index width; entries per bank = 2**INDEX_W.
- COLOR_W, 4, bits per colour channel.
- KEY_INDEX, 0, index reported as transparent.
- FLASH_FRAMES, 8, frames a hit flash lasts (1..255).

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- pix_valid  in  1  lookup request this cycle.
- pix_bank  in  $clog2(NUM_BANKS)  palette bank for lookup.
- pix_index  in  INDEX_W  palette index for lookup.
- wr_en  in  1  palette entry write strobe.
- wr_bank  in  $clog2(NUM_BANKS)  bank to write.
- wr_index  in  INDEX_W  entry to write.
- wr_rgb  in  3*COLOR_W  {red,green,blue} to write.
- frame_start  in  1  one-cycle pulse per video frame.
- flash_trig  in  1  one-cycle pulse that starts or restarts the hit flash.
- out_valid  out  1  output pixel valid.
- out_red  out  COLOR_W  red channel.
- out_green  out  COLOR_W  green channel.
- out_blue  out  COLOR_W  blue channel.
- out_transparent  out  1  pixel index equals KEY_INDEX.
- flash_active  out  1  flash countdown running.

Behaviour:

Reset:
- Clk and Reset_n is the only clocking: one clock; reset is asynchronous and active-low.
- Reset clears all palette entries to 0.
- All outputs go to 0; flash counter and phase go to 0.

Storage and writes:
- Palette is a NUM_BANKS x 2**INDEX_W register array of 3*COLOR_W bits.
- A write lands on the rising Clk edge with wr_en=1.
- A write to a bank >= NUM_BANKS is ignored.

Lookup pipeline, fixed latency 2:
- Stage 1 registers pix_valid, pix_bank and pix_index.
- Stage 2 reads the array combinationally using the stage-1 registers, then registers the colour, out_transparent and out_valid.
- A request at edge N appears at outputs after edge N+2.
- Back-to-back requests every cycle are supported; there is no stall.

Read/write ordering:
- The array read happens in stage 2.
- A write committed at the same edge as the stage-2 capture is NOT visible; the old value is output.
- A write committed at least one edge before the stage-2 capture is visible.

Invalid and out-of-range lookups:
- When the stage-2 valid is 0: out_valid=0, colour outputs hold their previous value, out_transparent=0.
- Lookup of a bank >= NUM_BANKS outputs colour 0 with out_valid=1.

Transparency:
- out_transparent = (index == KEY_INDEX), registered with the pixel.
- The colour of a transparent pixel is the stored entry; flash is never applied to it.

Flash state machine, states IDLE and FLASHING, with a counter cnt[7:0] and a phase bit:
- IDLE, flash_trig: go to FLASHING, cnt=FLASH_FRAMES, phase=1.
- FLASHING, frame_start without flash_trig: cnt decrements and phase toggles; when cnt becomes 0, go to IDLE with phase=0.
- FLASHING, flash_trig: reload cnt=FLASH_FRAMES and phase=1. Trigger wins over a simultaneous frame_start.
- flash_active=1 exactly while in FLASHING.
- Flash override is applied in stage 2: if phase=1 and the pixel is valid and non-transparent, all channels output 2**COLOR_W-1 (white).
- Phase is sampled at the stage-2 edge, so a mid-frame trigger takes effect on the pixel captured in the following stage-2 cycle.
- Reset asserted mid-flash returns to IDLE immediately.

Test Plan:
1. Reset with Reset_n=0 asynchronously mid-cycle -> all outputs 0 immediately. Then lookup bank 1 index 5 -> out_valid=1, rgb=000 two edges later.
2. Write bank 2 index 3 = 12'hA65, idle one cycle, then lookup (2,3) -> rgb A,6,5 at request edge+2. Lookup (0,3) -> 0,0,0.
3. Streaming: write index i = 12'h111*i in bank 0 for i=0..15, then 16 consecutive requests i=0..15 -> 16 consecutive valid outputs in order, index 0 flagged out_transparent=1, others 0.
4. Same-edge hazard: entry (1,4)=12'h123. Rewrite it with 12'hFED at the edge when the pending stage-2 capture occurs -> output 1,2,3. Next request returns F,E,D.
5. Flash with FLASH_FRAMES=3: trig, then frame_starts 1,2,3.
   - Before first frame_start: non-key pixel outputs F,F,F; key pixel outputs its stored colour.
   - After frame_start 1: stored colour.
   - After frame_start 2: white.
   - After frame_start 3: flash_active=0.
   - flash_trig and frame_start in the same cycle during FLASHING -> cnt=3, phase=1.
6. Out-of-range: NUM_BANKS=3. Write to bank 3 -> no change anywhere. Lookup bank 3 -> out_valid=1, rgb 0,0,0.
